// File: rtl/bus_mem_responder.sv
// Fixed-latency memory-mapped RAM target: byte/half/word loads and stores with one completion pulse per request.
// Optional macro BUS_MEM_RESPONDER_ERR_EN adds o_bus_err for misaligned or invalid-size accesses.
module bus_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_bus_address,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV,
    input  logic [2:0]  i_bhw,
    input  logic        i_write_notread,
    output logic [31:0] o_bus_data,
    output logic        o_bus_DV,
    output logic        o_busy
`ifdef BUS_MEM_RESPONDER_ERR_EN
    ,
    output logic        o_bus_err
`endif
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
`ifdef BUS_MEM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dv_q, dv_d;
    logic        busy_q, busy_d;
    logic [31:0] data_q, data_d;

    // Request captured at acceptance; held for the whole transaction.
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    lane_q, lane_d;
    size_t         size_q, size_d;
    logic          sgn_q, sgn_d;
    logic          wr_q, wr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;

    logic [31:0]   offset;
    logic          hit;
    logic [AW-1:0] in_idx;
    logic [1:0]    in_lane;
    size_t         in_size;
    logic          in_sgn;
    logic          in_err;

    // NOTE: every variable assigned in an always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        offset  = i_bus_address - BASE_ADDR;
        hit     = ({1'b0, offset} < SPAN);
        in_idx  = offset[AW+1:2];
        in_lane = offset[1:0];
        in_size = SZ_W;
        in_sgn  = 1'b0;
        in_err  = 1'b0;
        case (i_bhw)
            3'b000:  begin in_size = SZ_B; in_sgn = 1'b1; end
            3'b001:  begin in_size = SZ_H; in_sgn = 1'b1; end
            3'b010:  in_size = SZ_W;
            3'b100:  in_size = SZ_B;
            3'b101:  in_size = SZ_H;
            default: begin in_size = SZ_W; in_err = 1'b1; end
        endcase
        // Misaligned halves/words are forced down to their natural boundary.
        if (in_size == SZ_H) begin
            in_err     = in_err | in_lane[0];
            in_lane[0] = 1'b0;
        end else if (in_size == SZ_W) begin
            in_err  = in_err | (in_lane != 2'b00);
            in_lane = 2'b00;
        end
    end

    logic          capture;
    logic [AW-1:0] sel_idx;
    logic [1:0]    sel_lane;
    size_t         sel_size;
    logic          sel_sgn, sel_wr, sel_err;
    logic [31:0]   rword, rdata;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_bus_DV && hit) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        idx_d   = capture ? in_idx          : idx_q;
        lane_d  = capture ? in_lane         : lane_q;
        size_d  = capture ? in_size         : size_q;
        sgn_d   = capture ? in_sgn          : sgn_q;
        wr_d    = capture ? i_write_notread : wr_q;
        wdata_d = capture ? i_bus_data      : wdata_q;
        err_d   = capture ? in_err          : err_q;

        // With LATENCY==1 the response is formed straight from the accepting cycle's request.
        sel_idx  = (state_q == S_IDLE) ? in_idx          : idx_q;
        sel_lane = (state_q == S_IDLE) ? in_lane         : lane_q;
        sel_size = (state_q == S_IDLE) ? in_size         : size_q;
        sel_sgn  = (state_q == S_IDLE) ? in_sgn          : sgn_q;
        sel_wr   = (state_q == S_IDLE) ? i_write_notread : wr_q;
        sel_err  = (state_q == S_IDLE) ? in_err          : err_q;

        rword = mem[sel_idx];
        rbyte = rword[{sel_lane, 3'b000} +: 8];
        rhalf = rword[{sel_lane[1], 4'b0000} +: 16];
        case (sel_size)
            SZ_B:    rdata = sel_sgn ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
            SZ_H:    rdata = sel_sgn ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
            default: rdata = rword;
        endcase

        dv_d   = (state_d == S_RESP);
        busy_d = (state_d != S_IDLE);
        data_d = (dv_d && !sel_wr && !(ERR_EN && sel_err)) ? rdata : 32'h0;
    end

    // NOTE: sequential state uses non-blocking assignments only; next-state values come from the comb block.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        idx_q   <= idx_d;
        lane_q  <= lane_d;
        size_q  <= size_d;
        sgn_q   <= sgn_d;
        wr_q    <= wr_d;
        wdata_q <= wdata_d;
        err_q   <= err_d;
    end

    logic [3:0]  wr_be;
    logic [31:0] wr_word;
    logic        wr_commit;

    always_comb begin
        case (size_q)
            SZ_B:    begin wr_be = 4'b0001 << lane_q; wr_word = {4{wdata_q[7:0]}};  end
            SZ_H:    begin wr_be = 4'b0011 << lane_q; wr_word = {2{wdata_q[15:0]}}; end
            default: begin wr_be = 4'b1111;           wr_word = wdata_q;            end
        endcase
        wr_commit = (state_q == S_RESP) && wr_q && !(ERR_EN && err_q) && !i_rst;
    end

    // NOTE: the RAM array is deliberately not reset; only control state is, so contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[idx_q][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

`ifdef BUS_MEM_RESPONDER_ERR_EN
    logic bus_err_q, bus_err_d;

    always_comb begin
        bus_err_d = dv_d && sel_err;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) bus_err_q <= 1'b0;
        else       bus_err_q <= bus_err_d;
    end

    assign o_bus_err = bus_err_q;
`endif

    assign o_bus_data = data_q;
    assign o_bus_DV   = dv_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: two instances (LATENCY 2 and 1) checked against a byte-array reference model.
// Builds with or without BUS_MEM_RESPONDER_ERR_EN.
module tb_bus_mem_responder;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 64;
`ifdef BUS_MEM_RESPONDER_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  bhw = '0;
    logic        wr = 1'b0;
    logic [1:0]  dv_in = 2'b00;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  dv_out, busy, err_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [2][DEPTH*4];

    always #5 clk = ~clk;

    bus_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_l2 (
        .i_clk(clk), .i_rst(rst), .i_bus_address(addr), .i_bus_data(wdata),
        .i_bus_DV(dv_in[0]), .i_bhw(bhw), .i_write_notread(wr),
        .o_bus_data(rdata0), .o_bus_DV(dv_out[0]), .o_busy(busy[0])
`ifdef BUS_MEM_RESPONDER_ERR_EN
        , .o_bus_err(err_out[0])
`endif
    );

    bus_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
        .i_clk(clk), .i_rst(rst), .i_bus_address(addr), .i_bus_data(wdata),
        .i_bus_DV(dv_in[1]), .i_bhw(bhw), .i_write_notread(wr),
        .o_bus_data(rdata1), .o_bus_DV(dv_out[1]), .o_busy(busy[1])
`ifdef BUS_MEM_RESPONDER_ERR_EN
        , .o_bus_err(err_out[1])
`endif
    );

`ifndef BUS_MEM_RESPONDER_ERR_EN
    assign err_out = 2'b00;
`endif

    function automatic int lat_of(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int unsigned nbytes(logic [2:0] sz);
        case (sz)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit is_hit(logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic bit is_err(logic [31:0] a, logic [2:0] sz);
        int unsigned off;
        off = a - BASE;
        return ((off % nbytes(sz)) != 0) || (sz == 3'b011) || (sz == 3'b110) || (sz == 3'b111);
    endfunction

    // Reads n bytes little-endian from the naturally aligned start, then extends for signed codes.
    function automatic logic [31:0] model_load(int d, logic [31:0] a, logic [2:0] sz);
        int unsigned off, n, start;
        logic [31:0] v;
        off   = a - BASE;
        n     = nbytes(sz);
        start = off - (off % n);
        v     = 32'h0;
        for (int i = 0; i < int'(n); i++) v = v | (32'(mdl[d][start + i]) << (8 * i));
        if (sz == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (sz == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_store(int d, logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
        int unsigned off, n, start;
        off   = a - BASE;
        n     = nbytes(sz);
        start = off - (off % n);
        for (int i = 0; i < int'(n); i++) mdl[d][start + i] = 8'(wd >> (8 * i));
    endtask

    // Issues one request on instance d and records what the bus shows for a bounded window.
    // pester_until: keep i_bus_DV high with random request fields through that cycle; rst_k: pulse i_rst in that cycle.
    task automatic run_req(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] sz,
                           input logic w, input int pester_until, input int rst_k,
                           output int n_dv, output int dv_cyc, output logic [31:0] dat,
                           output logic er, output logic [15:0] bmask);
        int window;
        logic cur_dv, cur_er, cur_busy;
        logic [31:0] cur_dat;
        window = lat_of(d) + 3;
        n_dv = 0; dv_cyc = -1; dat = '0; er = 1'b0; bmask = '0;
        @(negedge clk);
        addr = a; wdata = wd; bhw = sz; wr = w;
        dv_in = 2'b00;
        dv_in[d] = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= window; k++) begin
            #1;
            dv_in[d] = (k <= pester_until);
            addr = $urandom; wdata = $urandom; bhw = 3'($urandom); wr = 1'($urandom);
            rst = (k == rst_k);
            cur_dv   = dv_out[d];
            cur_busy = busy[d];
            cur_er   = err_out[d];
            cur_dat  = (d == 0) ? rdata0 : rdata1;
            if (cur_dv) begin
                if (n_dv == 0) begin
                    dv_cyc = k; dat = cur_dat; er = cur_er;
                end
                n_dv++;
            end
            if (cur_busy) bmask[k] = 1'b1;
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        dv_in = 2'b00;
        if (w && is_hit(a) && rst_k == 0 && !(ERR && is_err(a, sz))) model_store(d, a, sz, wd);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dv_in = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dv_out !== 2'b00) begin errors++; $display("FAIL reset_dv: got %b expected 00", dv_out); end
        checks++;
        if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected 00", busy); end
        checks++;
        if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_data_l2: got %h expected 0", rdata0); end
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_data_l1: got %h expected 0", rdata1); end
        checks++;
        if (err_out !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", err_out); end
        rst = 1'b0;
    endtask

    task automatic test_init();
        int n, c; logic [31:0] dt; logic e; logic [15:0] m; logic [31:0] wd;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < DEPTH; w++) begin
                wd = $urandom;
                run_req(d, BASE + 32'(w * 4), wd, 3'b010, 1'b1, 0, 0, n, c, dt, e, m);
                checks++;
                if (n !== 1 || c != lat_of(d) || dt !== 32'h0) begin
                    errors++;
                    $display("FAIL init_sw d%0d w%0d: got n=%0d cyc=%0d data=%h expected n=1 cyc=%0d data=0",
                             d, w, n, c, dt, lat_of(d));
                end
            end
        end
    endtask

    task automatic test_word();
        int n, c; logic [31:0] dt; logic e; logic [15:0] m;
        run_req(0, 32'h10, 32'hDEAD_BEEF, 3'b010, 1'b1, 0, 0, n, c, dt, e, m);
        checks++;
        if (n !== 1 || c != 2 || dt !== 32'h0) begin
            errors++; $display("FAIL word_sw: got n=%0d cyc=%0d data=%h expected n=1 cyc=2 data=0", n, c, dt);
        end
        checks++;
        if (m !== 16'b0000_0000_0000_0110) begin
            errors++; $display("FAIL word_busy: got %b expected 0110", m);
        end
        run_req(0, 32'h10, 32'h0, 3'b010, 1'b0, 0, 0, n, c, dt, e, m);
        checks++;
        if (n !== 1 || c != 2 || dt !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL word_lw: got n=%0d cyc=%0d data=%h expected n=1 cyc=2 data=deadbeef", n, c, dt);
        end
    endtask

    task automatic test_extension();
        int n, c; logic [31:0] dt; logic e; logic [15:0] m;
        logic [31:0] a_tab [4]  = '{32'h23, 32'h23, 32'h22, 32'h20};
        logic [2:0]  sz_tab [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ex_tab [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
        run_req(0, 32'h20, 32'h80FF_7F01, 3'b010, 1'b1, 0, 0, n, c, dt, e, m);
        for (int i = 0; i < 4; i++) begin
            run_req(0, a_tab[i], 32'h0, sz_tab[i], 1'b0, 0, 0, n, c, dt, e, m);
            checks++;
            if (n !== 1 || dt !== ex_tab[i]) begin
                errors++; $display("FAIL ext_%0d: got n=%0d data=%h expected n=1 data=%h", i, n, dt, ex_tab[i]);
            end
        end
    endtask

    task automatic test_byte_lane();
        int n, c; logic [31:0] dt; logic e; logic [15:0] m;
        run_req(0, 32'h20, 32'h1122_3344, 3'b010, 1'b1, 0, 0, n, c, dt, e, m);
        run_req(0, 32'h21, 32'h0000_00AA, 3'b000, 1'b1, 0, 0, n, c, dt, e, m);
        run_req(0, 32'h20, 32'h0, 3'b010, 1'b0, 0, 0, n, c, dt, e, m);
        checks++;
        if (dt !== 32'h1122_AA44) begin errors++; $display("FAIL sb_lane: got %h expected 1122aa44", dt); end
        run_req(0, 32'h22, 32'hFFFF_5566, 3'b001, 1'b1, 0, 0, n, c, dt, e, m);
        run_req(0, 32'h20, 32'h0, 3'b010, 1'b0, 0, 0, n, c, dt, e, m);
        checks++;
        if (dt !== 32'h5566_AA44) begin errors++; $display("FAIL sh_lane: got %h expected 5566aa44", dt); end
    endtask

    task automatic test_miss();
        int n, c; logic [31:0] dt; logic e; logic [15:0] m; logic [31:0] exp_w0;
        exp_w0 = model_load(0, 32'h0, 3'b010);
        run_req(0, 32'(DEPTH * 4), 32'h5A5A_5A5A, 3'b010, 1'b1, 0, 0, n, c, dt, e, m);
        checks++;
        if (n !== 0 || m !== 16'h0) begin errors++; $display("FAIL miss_top: got n=%0d busy=%b expected n=0 busy=0", n, m); end
        run_req(0, 32'hFFFF_FFFC, 32'h0, 3'b010, 1'b0, 0, 0, n, c, dt, e, m);
        checks++;
        if (n !== 0) begin errors++; $display("FAIL miss_wrap: got n=%0d expected 0", n); end
        run_req(0, 32'h0, 32'h0, 3'b010, 1'b0, 0, 0, n, c, dt, e, m);
        checks++;
        if (dt !== exp_w0) begin errors++; $display("FAIL miss_alias: got %h expected %h", dt, exp_w0); end
    endtask

    task automatic test_back_to_back();
        int n, c; logic [31:0] dt; logic e; logic [15:0] m;
        for (int d = 0; d < 2; d++) begin
            run_req(d, 32'h40, 32'hA5A5_0000 + 32'(d), 3'b010, 1'b1, lat_of(d), 0, n, c, dt, e, m);
            checks++;
            if (n !== 1 || c != lat_of(d)) begin
                errors++; $display("FAIL busy_ignore d%0d: got n=%0d cyc=%0d expected n=1 cyc=%0d", d, n, c, lat_of(d));
            end
            run_req(d, 32'h40, 32'h0, 3'b010, 1'b0, 0, 0, n, c, dt, e, m);
            checks++;
            if (dt !== 32'hA5A5_0000 + 32'(d)) begin
                errors++; $display("FAIL busy_data d%0d: got %h expected %h", d, dt, 32'hA5A5_0000 + 32'(d));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, c; logic [31:0] dt; logic e; logic [15:0] m;
        run_req(0, 32'h30, 32'hCAFE_F00D, 3'b010, 1'b1, 0, 0, n, c, dt, e, m);
        run_req(0, 32'h30, 32'h1234_5678, 3'b010, 1'b1, 0, 1, n, c, dt, e, m);
        checks++;
        if (n !== 0) begin errors++; $display("FAIL rst_wait_dv: got n=%0d expected 0", n); end
        run_req(0, 32'h30, 32'h0, 3'b010, 1'b0, 0, 0, n, c, dt, e, m);
        checks++;
        if (dt !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_wait_mem: got %h expected cafef00d", dt); end
        run_req(0, 32'h30, 32'h1234_5678, 3'b010, 1'b1, 0, 2, n, c, dt, e, m);
        run_req(0, 32'h30, 32'h0, 3'b010, 1'b0, 0, 0, n, c, dt, e, m);
        checks++;
        if (dt !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_resp_mem: got %h expected cafef00d", dt); end
    endtask

    task automatic test_latency1_misalign();
        int n, c; logic [31:0] dt; logic e; logic [15:0] m;
        run_req(1, 32'h10, 32'h0A0B_0C0D, 3'b010, 1'b1, 0, 0, n, c, dt, e, m);
        run_req(1, 32'h13, 32'h0, 3'b010, 1'b0, 0, 0, n, c, dt, e, m);
        checks++;
        if (n !== 1 || c != 1 || m !== 16'b0010) begin
            errors++; $display("FAIL lat1_timing: got n=%0d cyc=%0d busy=%b expected n=1 cyc=1 busy=0010", n, c, m);
        end
        checks++;
        if (dt !== (ERR ? 32'h0 : 32'h0A0B_0C0D) || e !== ERR) begin
            errors++; $display("FAIL lat1_lw_mis: got data=%h err=%b expected data=%h err=%b",
                               dt, e, ERR ? 32'h0 : 32'h0A0B_0C0D, ERR);
        end
        run_req(1, 32'h11, 32'h0000_BEEF, 3'b001, 1'b1, 0, 0, n, c, dt, e, m);
        run_req(1, 32'h10, 32'h0, 3'b010, 1'b0, 0, 0, n, c, dt, e, m);
        checks++;
        if (dt !== (ERR ? 32'h0A0B_0C0D : 32'h0A0B_BEEF)) begin
            errors++; $display("FAIL lat1_sh_mis: got %h expected %h", dt, ERR ? 32'h0A0B_0C0D : 32'h0A0B_BEEF);
        end
        run_req(1, 32'h10, 32'h0, 3'b011, 1'b0, 0, 0, n, c, dt, e, m);
        checks++;
        if (dt !== (ERR ? 32'h0 : model_load(1, 32'h10, 3'b010)) || e !== ERR) begin
            errors++; $display("FAIL lat1_invalid: got data=%h err=%b expected data=%h err=%b",
                               dt, e, ERR ? 32'h0 : model_load(1, 32'h10, 3'b010), ERR);
        end
    endtask

    task automatic test_random();
        int n, c, d, lat; logic [31:0] dt; logic e; logic [15:0] m;
        logic [31:0] a, wd, exp_dat; logic [2:0] sz; logic w, hit, exp_err; logic [15:0] exp_m;
        for (int it = 0; it < 300; it++) begin
            d   = int'($urandom % 2);
            lat = lat_of(d);
            a   = (($urandom % 8) == 0) ? 32'(DEPTH * 4) + ($urandom % 1024) : BASE + ($urandom % (DEPTH * 4));
            sz  = 3'($urandom);
            w   = 1'($urandom);
            wd  = $urandom;
            hit = is_hit(a);
            exp_err = ERR && hit && is_err(a, sz);
            exp_dat = (w || exp_err) ? 32'h0 : model_load(d, a, sz);
            exp_m   = hit ? 16'(((1 << lat) - 1) << 1) : 16'h0;
            run_req(d, a, wd, sz, w, 0, 0, n, c, dt, e, m);
            checks++;
            if (n !== (hit ? 1 : 0) || m !== exp_m) begin
                errors++; $display("FAIL rnd_ctl %0d: got n=%0d busy=%b expected n=%0d busy=%b", it, n, m, hit ? 1 : 0, exp_m);
            end else if (hit) begin
                checks++;
                if (c != lat || dt !== exp_dat || e !== exp_err) begin
                    errors++;
                    $display("FAIL rnd_rsp %0d d%0d a=%h sz=%b w=%b: got cyc=%0d data=%h err=%b expected cyc=%0d data=%h err=%b",
                             it, d, a, sz, w, c, dt, e, lat, exp_dat, exp_err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_word();
        test_extension();
        test_byte_lane();
        test_miss();
        test_back_to_back();
        test_reset_mid();
        test_latency1_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
